operand_stack: RTL
==================

# operand_stack

Operand stack for the bytecode core. It is the responder side of the control unit's stack handshake. It accepts one-cycle push/pop requests over `trigger`/`push`/`stackwrite`, stores 32-bit words in a synchronous-read RAM, and answers each request with a single-cycle `done` pulse. Pop data is presented on `stackread`. The block sits between the control FSM and the on-chip block RAM.

## Interface
- `DEPTH`, 256: number of 32-bit entries; must be a power of two, ≥ 4.
- `AW`, `$clog2(DEPTH)`: pointer width (derived; do not override).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `trigger` in 1: request strobe; a request is the rising edge (`trigger & ~trigger_q`).
- `push` in 1: sampled with the accepted edge; 1 = push, 0 = pop.
- `stackwrite` in 32: push data, sampled with the accepted edge.
- `stackread` out 32: popped word; holds until the next completed pop.
- `stackdone` out 1: one-cycle completion pulse per accepted request.
- `count` out AW+1: current number of entries, 0..DEPTH.
- `busy` out 1: high whenever state ≠ IDLE.
- `overflow` out 1: sticky; only present with `STACK_GUARD_EN`.
- `underflow` out 1: sticky; only present with `STACK_GUARD_EN`.

## Operation
- Storage: `mem[0..DEPTH-1]`, single port, synchronous read (one-cycle read latency).
- Stack pointer `sp` (AW+1 bits) points at the next free slot. `count = sp`.
- `trigger_q` registers `trigger` every cycle. The rising edge is evaluated only in IDLE.
- States:
  - IDLE:
    - Rising edge with `push=1`: write `mem[sp[AW-1:0]] <= stackwrite`, `sp <= sp+1`, go to PUSH_ACK.
    - Rising edge with `push=0`: drive RAM address `sp-1`, `sp <= sp-1`, go to POP_RD.
  - PUSH_ACK: `stackdone <= 1` for this cycle, then return to IDLE.
  - POP_RD: RAM output valid. `stackread <= mem_q`, go to POP_ACK.
  - POP_ACK: `stackdone <= 1` for this cycle, then return to IDLE.
- Rising edges seen while not in IDLE are dropped. The control FSM never issues a new request before `stackdone`.
- A trigger held high through the `stackdone` cycle does not start a second request. It must drop low and rise again.
- LIFO order: pop returns the most recently pushed word not yet popped.
- Reset: `sp=0`, state IDLE, `stackread=0`, `stackdone=0`, `busy=0`, `trigger_q=0`, flags 0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts the request with no `stackdone`.

## Timing
- Cycle T is the cycle in which the rising edge is sampled in IDLE.
- Push: `stackdone=1` in T+1; `count` updated in T+1. Latency 1 cycle.
- Pop: `stackdone=1` and `stackread` valid in T+2; `count` updated in T+1. Latency 2 cycles.
- `busy` is high T+1 through the `stackdone` cycle inclusive.
- The earliest next accepted edge is the cycle after `stackdone`. This matches the control FSM re-asserting `trigger` on `stackdone`.
- Push followed by immediate pop returns the pushed word. There is no read-during-write hazard, because the write completes at the end of T and the read is issued at least 2 cycles later.

## Configuration
- `STACK_GUARD_EN` defined:
  - Push at `count==DEPTH`: no write, `sp` unchanged, `overflow` set.
  - Pop at `count==0`: `sp` unchanged, `stackread <= 0`, `underflow` set.
  - `stackdone` still pulses with normal latency in both cases.
  - Flags clear only on `rst`.
- `STACK_GUARD_EN` undefined:
  - No guard logic and no `overflow`/`underflow` ports.
  - `sp` wraps modulo 2^(AW+1); memory index uses `sp[AW-1:0]`.
  - Push at full or pop at empty produces data the design does not depend on.

## Test plan
- Reset then push `0x0000_002A`:
  - `stackdone` high exactly in T+1.
  - `count`=1.
  - `busy` 1 for one cycle.
- Push `0x11`, `0x22`, `0xFFFF_FF80`, then pop ×3:
  - `stackread` = `0xFFFF_FF80`, `0x22`, `0x11`, each valid with `stackdone` at T+2.
  - `count` ends at 0.
- Hold `trigger` high for 5 cycles with `push=1`, `stackwrite=0x5`:
  - Exactly one `stackdone`.
  - `count`=1.
  - Toggling `trigger` low→high re-issues the request.
- (`STACK_GUARD_EN`, `DEPTH=4`) push 5 words `1..5`:
  - 5th push sets `overflow`.
  - `count`=4.
  - Pop returns 4.
  - Pop ×4 more returns 3,2,1 then `0` with `underflow`=1.
- Assert `rst` in POP_RD after pushing `0x77`:
  - No `stackdone`.
  - `count`=0, `stackread`=0.
  - Next push/pop of `0x99` returns `0x99`.
- Back-to-back control-style sequence: pop, re-trigger on `stackdone`, pop, push result `0x0000_0008`:
  - Each request completes once.
  - Final `count` = initial − 1.

Source files
------------

// File: rtl/operand_stack.sv
// LIFO operand stack answering the control unit's trigger/stackdone handshake.
// Define STACK_GUARD_EN to add overflow/underflow protection and sticky flags.
module operand_stack #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trigger,
    input  logic          push,
    input  logic [31:0]   stackwrite,
    output logic [31:0]   stackread,
    output logic          stackdone,
    output logic [AW:0]   count,
    output logic          busy
`ifdef STACK_GUARD_EN
    ,
    output logic          overflow,
    output logic          underflow
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUSH_ACK = 2'd1,
        POP_RD   = 2'd2,
        POP_ACK  = 2'd3
    } state_t;

    localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADR_ONE = AW'(1);

    state_t        state_q, state_d;
    logic [AW:0]   sp_q, sp_d;
    logic [31:0]   stackread_q, stackread_d;
    logic          trigger_q;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   mem_q;
    logic          mem_we, mem_re;
    logic [AW-1:0] rd_addr;
    logic          req;

`ifdef STACK_GUARD_EN
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic empty_pop_q, empty_pop_d;
`endif

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        stackread_d = stackread_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        rd_addr     = sp_q[AW-1:0] - ADR_ONE;
        req         = trigger & ~trigger_q;
`ifdef STACK_GUARD_EN
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        empty_pop_d = empty_pop_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (push) begin
                        state_d = PUSH_ACK;
`ifdef STACK_GUARD_EN
                        if (sp_q == SP_FULL) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                            sp_d   = sp_q + SP_ONE;
                        end
`else
                        mem_we = 1'b1;
                        sp_d   = sp_q + SP_ONE;
`endif
                    end else begin
                        state_d = POP_RD;
`ifdef STACK_GUARD_EN
                        empty_pop_d = (sp_q == '0);
                        if (sp_q == '0) begin
                            underflow_d = 1'b1;
                        end else begin
                            mem_re = 1'b1;
                            sp_d   = sp_q - SP_ONE;
                        end
`else
                        mem_re = 1'b1;
                        sp_d   = sp_q - SP_ONE;
`endif
                    end
                end
            end
            PUSH_ACK: state_d = IDLE;
            POP_RD: begin
                // RAM output registered last cycle is valid now
`ifdef STACK_GUARD_EN
                stackread_d = empty_pop_q ? 32'd0 : mem_q;
`else
                stackread_d = mem_q;
`endif
                state_d = POP_ACK;
            end
            POP_ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sp_q        <= '0;
            stackread_q <= '0;
            trigger_q   <= 1'b0;
`ifdef STACK_GUARD_EN
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            empty_pop_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            stackread_q <= stackread_d;
            trigger_q   <= trigger;
`ifdef STACK_GUARD_EN
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            empty_pop_q <= empty_pop_d;
`endif
        end
    end

    // Contents survive reset; a request coinciding with rst must not write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[sp_q[AW-1:0]] <= stackwrite;
        end
        if (mem_re) begin
            mem_q <= mem[rd_addr];
        end
    end

    assign stackread = stackread_q;
    assign stackdone = (state_q == PUSH_ACK) || (state_q == POP_ACK);
    assign busy      = (state_q != IDLE);
    assign count     = sp_q;
`ifdef STACK_GUARD_EN
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
